// File: rtl/san_cnt_core_if.sv
// san_cnt_core_if: register-file control/config into the counter core, count and status back out
interface san_cnt_core_if #(
  parameter int C_CNT_WIDTH = 32,
  parameter int C_PRESCALE_WIDTH = 16
);
  logic ctrl_en;
  logic ctrl_oneshot;
  logic ctrl_clr;
  logic [C_PRESCALE_WIDTH-1:0] prescale;
  logic [C_CNT_WIDTH-1:0] period;
  logic [C_CNT_WIDTH-1:0] cnt_value;
  logic running;
  logic done;
  logic intr_pulse;
  modport master (
    output ctrl_en, ctrl_oneshot, ctrl_clr, prescale, period,
    input  cnt_value, running, done, intr_pulse
  );
  modport slave (
    input  ctrl_en, ctrl_oneshot, ctrl_clr, prescale, period,
    output cnt_value, running, done, intr_pulse
  );
endinterface

// File: rtl/san_cnt_core.sv
// san_cnt_core: prescaled up-counter with free-run/oneshot modes and a one-cycle terminal-count pulse
module san_cnt_core #(
  parameter int C_CNT_WIDTH = 32,
  parameter int C_PRESCALE_WIDTH = 16
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESETN,
  san_cnt_core_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [C_PRESCALE_WIDTH-1:0] pre;
  logic [C_CNT_WIDTH-1:0] cnt;
  logic intr;
  logic tick, term;
  assign tick = (state == RUN) && (pre == bus.prescale);
  // >= so that a period lowered below the current count terminates on the next tick
  assign term = tick && (cnt >= bus.period);
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      cnt <= '0;
      pre <= '0;
      intr <= 1'b0;
    end else begin
      intr <= 1'b0;
      if (bus.ctrl_clr) begin
        cnt <= '0;
        pre <= '0;
        if (state == DONE) state <= IDLE;
      end else if (state == IDLE) begin
        if (bus.ctrl_en) begin
          state <= RUN;
          cnt <= '0;
          pre <= '0;
        end
      end else if (state != RUN) begin
        if (!bus.ctrl_en || state != DONE) state <= IDLE;
      end else if (!bus.ctrl_en) begin
        state <= IDLE;
        pre <= '0;
      end else if (term) begin
        intr <= 1'b1;
        pre <= '0;
        if (bus.ctrl_oneshot) state <= DONE;
        else cnt <= '0;
      end else if (tick) begin
        pre <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end
  assign bus.cnt_value = cnt;
  assign bus.running = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.intr_pulse = intr;
endmodule

// File: tb/tb_san_cnt_core.sv
// tb_san_cnt_core: per-cycle stimulus with hand-derived expectations checked through a scoreboard queue
module tb_san_cnt_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  san_cnt_core_if #(.C_CNT_WIDTH(32), .C_PRESCALE_WIDTH(16)) bus ();
  san_cnt_core #(.C_CNT_WIDTH(32), .C_PRESCALE_WIDTH(16)) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .bus(bus)
  );
  typedef struct packed {
    logic [31:0] cnt;
    logic run;
    logic done;
    logic intr;
  } exp_t;
  typedef struct {
    logic en;
    logic os;
    logic clr;
    logic [15:0] ps;
    logic [31:0] per;
    exp_t exp;
  } vec_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  function automatic exp_t mk(input int c, input logic r, input logic d, input logic i);
    mk = {32'(c), r, d, i};
  endfunction
  task automatic step(input logic rn, input logic en, input logic os, input logic clr,
                      input logic [15:0] ps, input logic [31:0] per, input exp_t e, input string name);
    exp_t got, want;
    rst_n = rn;
    bus.ctrl_en = en;
    bus.ctrl_oneshot = os;
    bus.ctrl_clr = clr;
    bus.prescale = ps;
    bus.period = per;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.cnt_value, bus.running, bus.done, bus.intr_pulse};
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got cnt=%0d run=%b done=%b intr=%b, want cnt=%0d run=%b done=%b intr=%b",
               name, got.cnt, got.run, got.done, got.intr, want.cnt, want.run, want.done, want.intr);
    end
  endtask
  task automatic s(input logic en, input logic os, input logic clr, input logic [15:0] ps,
                   input logic [31:0] per, input int c, input logic r, input logic d, input logic i,
                   input string name);
    step(1'b1, en, os, clr, ps, per, mk(c, r, d, i), name);
  endtask
  initial begin
    vec_t ft[9];
    ft[0] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(0, 1, 0, 0)};
    ft[1] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(1, 1, 0, 0)};
    ft[2] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(2, 1, 0, 0)};
    ft[3] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(3, 1, 0, 0)};
    ft[4] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(0, 1, 0, 1)};
    ft[5] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(1, 1, 0, 0)};
    ft[6] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(2, 1, 0, 0)};
    ft[7] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(3, 1, 0, 0)};
    ft[8] = '{1'b1, 1'b0, 1'b0, 16'd0, 32'd3, mk(0, 1, 0, 1)};
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, mk(0, 0, 0, 0), "reset0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'd0, mk(0, 0, 0, 0), "reset1");
    for (int i = 0; i < 9; i++)
      step(1'b1, ft[i].en, ft[i].os, ft[i].clr, ft[i].ps, ft[i].per, ft[i].exp, $sformatf("freerun%0d", i));
    s(0, 0, 0, 0, 3, 0, 0, 0, 0, "fr_stop");
    for (int i = 1; i <= 21; i++)
      s(1, 0, 0, 4, 1, ((i - 1) / 5) % 2, 1, 0, (i == 11 || i == 21), $sformatf("pre%0d", i));
    s(0, 0, 0, 4, 1, 0, 0, 0, 0, "pre_stop");
    s(1, 1, 0, 0, 5, 0, 1, 0, 0, "os_start");
    for (int i = 1; i <= 5; i++) s(1, 1, 0, 0, 5, i, 1, 0, 0, "os_cnt");
    s(1, 1, 0, 0, 5, 5, 0, 1, 1, "os_term");
    for (int i = 0; i < 3; i++) s(1, 1, 0, 0, 5, 5, 0, 1, 0, "os_hold");
    s(0, 1, 0, 0, 5, 5, 0, 0, 0, "os_idle");
    s(1, 1, 0, 0, 5, 0, 1, 0, 0, "os_restart");
    for (int i = 1; i <= 5; i++) s(1, 1, 0, 0, 5, i, 1, 0, 0, "os_cnt2");
    s(1, 1, 0, 0, 5, 5, 0, 1, 1, "os_term2");
    s(1, 1, 1, 0, 5, 0, 0, 0, 0, "clr_done");
    s(1, 1, 0, 0, 5, 0, 1, 0, 0, "clr_reen");
    s(0, 0, 0, 0, 5, 0, 0, 0, 0, "os_stop");
    s(1, 0, 0, 0, 20, 0, 1, 0, 0, "pz_start");
    for (int i = 1; i <= 7; i++) s(1, 0, 0, 0, 20, i, 1, 0, 0, "pz_cnt");
    s(0, 0, 0, 0, 20, 7, 0, 0, 0, "pause");
    s(0, 0, 0, 0, 20, 7, 0, 0, 0, "pause_hold");
    s(1, 0, 0, 0, 2, 0, 1, 0, 0, "ct_start");
    s(1, 0, 0, 0, 2, 1, 1, 0, 0, "ct_cnt1");
    s(1, 0, 0, 0, 2, 2, 1, 0, 0, "ct_cnt2");
    s(1, 0, 1, 0, 2, 0, 1, 0, 0, "clr_term");
    s(1, 0, 0, 0, 2, 1, 1, 0, 0, "clr_next");
    s(1, 0, 0, 0, 2, 2, 1, 0, 0, "clr_next2");
    s(1, 0, 0, 0, 2, 0, 1, 0, 1, "clr_after_term");
    s(1, 0, 0, 0, 2, 1, 1, 0, 0, "st_cnt1");
    s(1, 0, 0, 0, 2, 2, 1, 0, 0, "st_cnt2");
    s(0, 0, 0, 0, 2, 2, 0, 0, 0, "stop_term");
    s(1, 0, 0, 0, 20, 0, 1, 0, 0, "sh_start");
    for (int i = 1; i <= 10; i++) s(1, 0, 0, 0, 20, i, 1, 0, 0, "sh_cnt");
    s(1, 0, 0, 0, 4, 0, 1, 0, 1, "shrink");
    s(1, 0, 0, 0, 4, 1, 1, 0, 0, "shrink_next");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'd4, mk(0, 0, 0, 0), "rst_run");
    s(1, 0, 0, 0, 4, 0, 1, 0, 0, "rst_reen");
    s(1, 0, 0, 0, 4, 1, 1, 0, 0, "rst_cnt1");
    s(0, 0, 0, 0, 0, 1, 0, 0, 0, "zz_idle");
    s(1, 0, 0, 0, 0, 0, 1, 0, 0, "zz_start");
    for (int i = 0; i < 3; i++) s(1, 0, 0, 0, 0, 0, 1, 0, 1, "zz_cont");
    s(0, 0, 0, 0, 0, 0, 0, 0, 0, "zz_stop");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
